// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding select, load-use bubbles, redirect flush and multi-cycle freeze for a 5-stage pipe
module pipe_hazard_ctrl #(
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_rf_we,
  input  logic [4:0]       ex_rf_waddr,
  input  logic             ex_is_load,
  input  logic             mem_rf_we,
  input  logic [4:0]       mem_rf_waddr,
  input  logic             mem_is_load,
  input  logic             wb_rf_we,
  input  logic [4:0]       wb_rf_waddr,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             ex_redirect,
  output logic             pc_ena,
  output logic             pc_sel_redirect,
  output logic             id_reg_ena,
  output logic             id_reg_valid,
  output logic             ex_reg_ena,
  output logic             ex_reg_valid,
  output logic             mem_reg_ena,
  output logic             mem_reg_valid,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WD_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN = 2'd0, MC_WAIT = 2'd1} state_e;
  state_e state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic mc_timeout_q, mc_timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic ex_a, mem_a, wb_a, ex_b, mem_b, wb_b;
  logic [1:0] raw_a, raw_b;
  logic load_use, mc_busy, redirect;
  assign ex_a  = id_rs1_used && id_rs1 != 5'd0 && ex_rf_we  && ex_rf_waddr  == id_rs1;
  assign mem_a = id_rs1_used && id_rs1 != 5'd0 && mem_rf_we && mem_rf_waddr == id_rs1;
  assign wb_a  = id_rs1_used && id_rs1 != 5'd0 && wb_rf_we  && wb_rf_waddr  == id_rs1;
  assign ex_b  = id_rs2_used && id_rs2 != 5'd0 && ex_rf_we  && ex_rf_waddr  == id_rs2;
  assign mem_b = id_rs2_used && id_rs2 != 5'd0 && mem_rf_we && mem_rf_waddr == id_rs2;
  assign wb_b  = id_rs2_used && id_rs2 != 5'd0 && wb_rf_we  && wb_rf_waddr  == id_rs2;
  assign raw_a = (ex_a && !ex_is_load) ? 2'b01 : (mem_a && !mem_is_load) ? 2'b10 : wb_a ? 2'b11 : 2'b00;
  assign raw_b = (ex_b && !ex_is_load) ? 2'b01 : (mem_b && !mem_is_load) ? 2'b10 : wb_b ? 2'b11 : 2'b00;
  // a load is only a hazard when it is the nearest producer of the operand
  assign load_use = (ex_a ? ex_is_load : mem_a && mem_is_load) || (ex_b ? ex_is_load : mem_b && mem_is_load);
  assign mc_busy  = (state_q == RUN) ? ex_mc_start && !ex_mc_done : !ex_mc_done;
  assign redirect = ex_redirect && !mc_busy;
  assign mc_timeout = mc_timeout_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  // stage control by priority: reset, multi-cycle freeze, redirect, load-use, free flow
  always_comb begin
    pc_ena          = 1'b1;
    pc_sel_redirect = 1'b0;
    id_reg_ena      = 1'b1;
    id_reg_valid    = 1'b1;
    ex_reg_ena      = 1'b1;
    ex_reg_valid    = 1'b1;
    mem_reg_ena     = 1'b1;
    mem_reg_valid   = 1'b1;
    fwd_sel_a       = raw_a;
    fwd_sel_b       = raw_b;
    if (rst) begin
      id_reg_valid  = 1'b0;
      ex_reg_valid  = 1'b0;
      mem_reg_valid = 1'b0;
      fwd_sel_a     = 2'b00;
      fwd_sel_b     = 2'b00;
    end else if (mc_busy) begin
      pc_ena        = 1'b0;
      id_reg_ena    = 1'b0;
      ex_reg_ena    = 1'b0;
      mem_reg_valid = 1'b0;
    end else if (redirect) begin
      pc_sel_redirect = 1'b1;
      id_reg_valid    = 1'b0;
      ex_reg_valid    = 1'b0;
    end else if (load_use) begin
      pc_ena       = 1'b0;
      id_reg_ena   = 1'b0;
      ex_reg_valid = 1'b0;
    end
  end
  // next state, watchdog and event counters
  always_comb begin
    state_d      = state_q;
    wd_d         = wd_q;
    mc_timeout_d = mc_timeout_q;
    stall_d      = stall_q + CNT_W'(!pc_ena);
    flush_d      = flush_q + CNT_W'(redirect);
    if (state_q == RUN && mc_busy) begin
      state_d = MC_WAIT;
      wd_d    = '0;
    end else if (state_q == MC_WAIT) begin
      mc_timeout_d = mc_timeout_q || wd_q == WD_LAST;
      wd_d         = wd_q + WD_W'(wd_q != WD_LAST);
      state_d      = ex_mc_done ? RUN : MC_WAIT;
    end
  end
  // state and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      wd_q         <= '0;
      mc_timeout_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      wd_q         <= wd_d;
      mc_timeout_q <= mc_timeout_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized run against a behavioural model
module tb_pipe_hazard_ctrl;
  localparam int MCT = 8;
  localparam int CW  = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rf_waddr, mem_rf_waddr, wb_rf_waddr;
  logic id_rs1_used, id_rs2_used, ex_rf_we, ex_is_load, mem_rf_we, mem_is_load, wb_rf_we;
  logic ex_mc_start, ex_mc_done, ex_redirect;
  logic pc_ena, pc_sel_redirect, id_reg_ena, id_reg_valid, ex_reg_ena, ex_reg_valid, mem_reg_ena, mem_reg_valid;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic mc_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [11:0] act_v;
  int checks = 0;
  int errors = 0;
  logic m_wait, m_to, exp_redir;
  int m_wc;
  logic [CW-1:0] m_stall, m_flush;
  logic [11:0] exp_v;

  pipe_hazard_ctrl #(.MC_TIMEOUT(MCT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_is_load(ex_is_load),
    .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr), .mem_is_load(mem_is_load),
    .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .ex_redirect(ex_redirect), .pc_ena(pc_ena), .pc_sel_redirect(pc_sel_redirect),
    .id_reg_ena(id_reg_ena), .id_reg_valid(id_reg_valid), .ex_reg_ena(ex_reg_ena), .ex_reg_valid(ex_reg_valid),
    .mem_reg_ena(mem_reg_ena), .mem_reg_valid(mem_reg_valid), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .mc_timeout(mc_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign act_v = {pc_ena, pc_sel_redirect, id_reg_ena, id_reg_valid, ex_reg_ena, ex_reg_valid,
                  mem_reg_ena, mem_reg_valid, fwd_sel_a, fwd_sel_b};

  always #5 clk = ~clk;

  task automatic clear_inputs;
    {id_rs1, id_rs2, ex_rf_waddr, mem_rf_waddr, wb_rf_waddr} = '0;
    {id_rs1_used, id_rs2_used, ex_rf_we, ex_is_load, mem_rf_we, mem_is_load, wb_rf_we} = '0;
    {ex_mc_start, ex_mc_done, ex_redirect} = '0;
  endtask

  task automatic random_inputs;
    id_rs1 = 5'($urandom_range(0, 7));
    id_rs2 = 5'($urandom_range(0, 7));
    ex_rf_waddr = 5'($urandom_range(0, 7));
    mem_rf_waddr = 5'($urandom_range(0, 7));
    wb_rf_waddr = 5'($urandom_range(0, 7));
    id_rs1_used = 1'($urandom_range(0, 1));
    id_rs2_used = 1'($urandom_range(0, 1));
    ex_rf_we = 1'($urandom_range(0, 1));
    mem_rf_we = 1'($urandom_range(0, 1));
    wb_rf_we = 1'($urandom_range(0, 1));
    ex_is_load = ($urandom_range(0, 3) == 0);
    mem_is_load = ($urandom_range(0, 3) == 0);
    ex_redirect = ($urandom_range(0, 5) == 0);
    ex_mc_start = ($urandom_range(0, 7) == 0);
    ex_mc_done = ($urandom_range(0, 4) == 0);
  endtask

  // operand source: scan producers EX, MEM, WB nearest first
  task automatic operand(input logic used, input logic [4:0] rs, output logic [1:0] sel, output logic lu);
    logic [4:0] wa[3];
    logic we[3];
    logic ld[3];
    logic found;
    wa = '{ex_rf_waddr, mem_rf_waddr, wb_rf_waddr};
    we = '{ex_rf_we, mem_rf_we, wb_rf_we};
    ld = '{ex_is_load, mem_is_load, 1'b0};
    sel = 2'd0;
    lu = 1'b0;
    found = 1'b0;
    if (used && rs != 0)
      for (int k = 0; k < 3; k++)
        if (we[k] && wa[k] == rs) begin
          if (!found) lu = ld[k];
          found = 1'b1;
          if (sel == 2'd0 && !ld[k]) sel = 2'(k + 1);
        end
  endtask

  task automatic model_eval;
    logic [1:0] sa, sb;
    logic la, lb, busy;
    operand(id_rs1_used, id_rs1, sa, la);
    operand(id_rs2_used, id_rs2, sb, lb);
    busy = m_wait ? !ex_mc_done : (ex_mc_start && !ex_mc_done);
    exp_redir = ex_redirect && !busy;
    if (busy) exp_v = {8'b0001_0110, sa, sb};
    else if (exp_redir) exp_v = {8'b1110_1011, sa, sb};
    else if (la || lb) exp_v = {8'b0001_1011, sa, sb};
    else exp_v = {8'b1011_1111, sa, sb};
    if (rst) exp_v = 12'b1010_1010_0000;
  endtask

  task automatic model_update;
    logic busy;
    busy = m_wait ? !ex_mc_done : (ex_mc_start && !ex_mc_done);
    if (!exp_v[11]) m_stall++;
    if (exp_redir) m_flush++;
    if (!m_wait && busy) begin
      m_wait = 1'b1;
      m_wc = 0;
    end else if (m_wait) begin
      m_wc++;
      if (m_wc >= MCT) m_to = 1'b1;
      if (ex_mc_done) m_wait = 1'b0;
    end
  endtask

  task automatic model_reset;
    m_wait = 1'b0;
    m_to = 1'b0;
    m_wc = 0;
    m_stall = '0;
    m_flush = '0;
  endtask

  task automatic tick;
    model_eval;
    model_update;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs;
    #2;
    model_reset;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clear_inputs;
    ex_rf_we = 1'b1; ex_rf_waddr = 5'd6; ex_is_load = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
    tick;
    clear_inputs;
    tick;
    @(negedge clk);
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL pre_reset_stall got %0d want 1", stall_cnt); end
    rst = 1'b1;
    random_inputs;
    #2;
    checks++; if (act_v !== 12'b1010_1010_0000) begin errors++; $display("FAIL reset_outputs got %b want 101010100000", act_v); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    checks++; if (mc_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", mc_timeout); end
    do_reset;
  endtask

  task automatic test_alu_chain;
    logic [CW-1:0] base;
    clear_inputs;
    base = m_stall;
    ex_rf_we = 1'b1; ex_rf_waddr = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    @(negedge clk);
    checks++; if (fwd_sel_a !== 2'b01 || pc_ena !== 1'b1) begin errors++; $display("FAIL alu_fwd_ex got sel=%b pc=%b want sel=01 pc=1", fwd_sel_a, pc_ena); end
    tick;
    mem_rf_we = 1'b1; mem_rf_waddr = 5'd5; ex_rf_waddr = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    @(negedge clk);
    checks++; if ({fwd_sel_a, fwd_sel_b} !== 4'b1001) begin errors++; $display("FAIL alu_fwd_mem_ex got %b want 1001", {fwd_sel_a, fwd_sel_b}); end
    checks++; if (stall_cnt !== base) begin errors++; $display("FAIL alu_no_stall got %0d want %0d", stall_cnt, base); end
    tick;
  endtask

  task automatic test_load_use;
    logic [CW-1:0] base;
    clear_inputs;
    base = m_stall;
    ex_rf_we = 1'b1; ex_rf_waddr = 5'd6; ex_is_load = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (act_v[11:4] !== 8'b0001_1011) begin errors++; $display("FAIL load_use_bubble%0d got %b want 00011011", i, act_v[11:4]); end
      tick;
      clear_inputs;
      id_rs2 = 5'd6; id_rs2_used = 1'b1;
      if (i == 0) begin mem_rf_we = 1'b1; mem_rf_waddr = 5'd6; mem_is_load = 1'b1; end
      else begin wb_rf_we = 1'b1; wb_rf_waddr = 5'd6; end
    end
    @(negedge clk);
    checks++; if (fwd_sel_b !== 2'b11 || pc_ena !== 1'b1) begin errors++; $display("FAIL load_use_wb got sel=%b pc=%b want sel=11 pc=1", fwd_sel_b, pc_ena); end
    checks++; if (stall_cnt !== base + 2) begin errors++; $display("FAIL load_use_stalls got %0d want %0d", stall_cnt, base + 2); end
    tick;
  endtask

  task automatic test_x0;
    clear_inputs;
    ex_rf_we = 1'b1; ex_rf_waddr = 5'd0; ex_is_load = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    @(negedge clk);
    checks++; if (fwd_sel_a !== 2'b00 || pc_ena !== 1'b1 || ex_reg_valid !== 1'b1) begin errors++; $display("FAIL x0_source got sel=%b pc=%b exv=%b want 00/1/1", fwd_sel_a, pc_ena, ex_reg_valid); end
    tick;
  endtask

  task automatic test_redirect_load;
    logic [CW-1:0] base;
    clear_inputs;
    base = m_flush;
    ex_rf_we = 1'b1; ex_rf_waddr = 5'd6; ex_is_load = 1'b1; id_rs2 = 5'd6; id_rs2_used = 1'b1; ex_redirect = 1'b1;
    @(negedge clk);
    checks++; if (act_v[11:4] !== 8'b1110_1011) begin errors++; $display("FAIL redirect_over_load got %b want 11101011", act_v[11:4]); end
    tick;
    clear_inputs;
    @(negedge clk);
    checks++; if (flush_cnt !== base + 1) begin errors++; $display("FAIL redirect_flush_cnt got %0d want %0d", flush_cnt, base + 1); end
    tick;
  endtask

  task automatic test_multicycle;
    logic [CW-1:0] base;
    clear_inputs;
    base = m_stall;
    ex_mc_start = 1'b1;
    ex_redirect = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (act_v[11:4] !== 8'b0001_0110) begin errors++; $display("FAIL mc_freeze%0d got %b want 00010110", i, act_v[11:4]); end
      tick;
      ex_mc_start = 1'b0;
    end
    ex_mc_done = 1'b1;
    ex_redirect = 1'b0;
    @(negedge clk);
    checks++; if (mem_reg_valid !== 1'b1 || ex_reg_ena !== 1'b1 || pc_ena !== 1'b1) begin errors++; $display("FAIL mc_done got memv=%b exe=%b pc=%b want 1/1/1", mem_reg_valid, ex_reg_ena, pc_ena); end
    tick;
    ex_mc_done = 1'b0;
    @(negedge clk);
    checks++; if (pc_ena !== 1'b1) begin errors++; $display("FAIL mc_back_to_run got pc=%b want 1", pc_ena); end
    checks++; if (stall_cnt !== base + 5 || flush_cnt !== m_flush) begin errors++; $display("FAIL mc_counters got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, base + 5, m_flush); end
    tick;
  endtask

  task automatic test_timeout;
    clear_inputs;
    ex_mc_start = 1'b1;
    tick;
    ex_mc_start = 1'b0;
    for (int i = 1; i <= MCT; i++) begin
      @(negedge clk);
      checks++; if (mc_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early cycle %0d got %b want 0", i, mc_timeout); end
      tick;
    end
    @(negedge clk);
    checks++; if (mc_timeout !== 1'b1 || pc_ena !== 1'b0) begin errors++; $display("FAIL timeout_set got to=%b pc=%b want 1/0", mc_timeout, pc_ena); end
    tick;
    rst = 1'b1;
    #2;
    checks++; if (mc_timeout !== 1'b0) begin errors++; $display("FAIL timeout_cleared got %b want 0", mc_timeout); end
    do_reset;
    @(negedge clk);
    checks++; if (pc_ena !== 1'b1 || stall_cnt !== 0) begin errors++; $display("FAIL reset_to_run got pc=%b stall=%0d want 1/0", pc_ena, stall_cnt); end
    tick;
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      random_inputs;
      @(negedge clk);
      model_eval;
      checks++; if (act_v !== exp_v) begin errors++; $display("FAIL rand_ctl cycle %0d got %b want %b", i, act_v, exp_v); end
      checks++; if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin errors++; $display("FAIL rand_cnt cycle %0d got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, m_stall, m_flush); end
      checks++; if (mc_timeout !== m_to) begin errors++; $display("FAIL rand_timeout cycle %0d got %b want %b", i, mc_timeout, m_to); end
      tick;
    end
  endtask

  initial begin
    clear_inputs;
    model_reset;
    #12;
    do_reset;
    test_reset;
    test_alu_chain;
    test_load_use;
    test_x0;
    test_redirect_load;
    test_multicycle;
    test_timeout;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
